// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/issue/writeback sequencer that drives an
// external registered 8-bit ALU from a 16-bit instruction stream.
module alu_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        imem_req,
    output logic [5:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [2:0]  alu_instr,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [5:0]  alu_branch_addr,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    input  logic        alu_eq,
    input  logic        alu_branch,
    output logic [5:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        carry,
    output logic        eq,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WB, HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir;
    logic [7:0]  r [4];

    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [5:0]  tgt;

    logic [2:0]  f_op;
    logic        f_ldi;
    logic        f_halt;

    // the branch-taken flag comes from our own eq latch instead
    logic        unused;

    assign op   = ir[15:13];
    assign rd   = ir[12:11];
    assign rs1  = ir[10:9];
    assign rs2  = ir[8:7];
    assign tgt  = ir[5:0];

    // control ops are resolved straight off the fetch bus
    assign f_op   = imem_data[15:13];
    assign f_ldi  = imem_data[10];
    assign f_halt = !imem_data[10] && imem_data[9];

    assign unused    = ^{alu_branch, ir[6], imem_data[8]};
    assign imem_addr = pc;
    assign dbg_data  = r[dbg_sel];

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (f_op != 3'd0) state_nx = ISSUE;
                    else if (f_halt)  state_nx = HALT;
                end
            end
            ISSUE: state_nx = WB;
            WB:    state_nx = FETCH;
            HALT:  state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // handshake, ALU drive and status decode
    always_comb begin
        imem_req        = 1'b0;
        alu_instr       = 3'd0;
        alu_A           = 8'd0;
        alu_B           = 8'd0;
        alu_branch_addr = 6'd0;
        busy            = 1'b0;
        halted          = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            ISSUE: begin
                busy            = 1'b1;
                alu_instr       = op;
                alu_A           = r[rs1];
                alu_B           = r[rs2];
                alu_branch_addr = tgt;
            end
            WB:      busy   = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // architectural state: PC, IR, register file, flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= 6'd0;
            ir    <= 16'd0;
            carry <= 1'b0;
            eq    <= 1'b0;
            r     <= '{default: 8'd0};
        end else begin
            case (state)
                IDLE: if (start) pc <= 6'd0;
                FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        if (f_op == 3'd0) begin
                            if (f_ldi)
                                r[imem_data[12:11]] <= imem_data[7:0];
                            if (!f_halt) pc <= pc + 6'd1;
                        end
                    end
                end
                WB: begin
                    carry <= 1'b0;
                    eq    <= 1'b0;
                    pc    <= pc + 6'd1;
                    if (op == 3'd7) begin
                        if (eq) pc <= tgt;
                    end else begin
                        r[rd] <= alu_out;
                        if (op == 3'd1 || op == 3'd2)
                            carry <= alu_co;
                        if (op == 3'd6)
                            eq <= alu_eq;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1, a pulse in IDLE that begins execution at PC 0.
REQ-004 SHALL have ports imem_req (out, 1), imem_addr (out, 6), imem_ack (in, 1) and imem_data (in, 16), the instruction fetch handshake.
REQ-005 SHALL have ports alu_instr (out, 3), alu_A (out, 8), alu_B (out, 8) and alu_branch_addr (out, 6), which drive the 8-bit registered ALU.
REQ-006 SHALL have ports alu_out (in, 8), alu_co (in, 1), alu_eq (in, 1) and alu_branch (in, 1), the ALU results, valid one cycle after issue.
REQ-007 SHALL have ports pc (out, 6), busy (out, 1), halted (out, 1), carry (out, 1) and eq (out, 1), the status outputs.
REQ-008 SHALL have ports dbg_sel (in, 2) and dbg_data (out, 8), a combinational read of register R[dbg_sel].

Function
REQ-009 SHALL contain four 8-bit registers R0..R3, a 6-bit PC, a 16-bit IR and latches for carry and eq.
REQ-010 SHALL decode IR fields as op=[15:13], rd=[12:11], rs1=[10:9], rs2=[8:7], target=[5:0] and imm=[7:0].
REQ-011 SHALL treat op=000 as a control op: bit10=1 is LDI (R[rd]<=imm), else bit9=1 is HALT, else NOP.
REQ-012 SHALL implement the FSM states IDLE, FETCH, ISSUE, WB and HALT.
REQ-013 SHALL make the IDLE transition: start=1 -> FETCH with PC=0; start is ignored in every other state.
REQ-014 SHALL hold imem_req=1 and imem_addr=PC in FETCH; on imem_ack=1, IR<=imem_data.
REQ-015 SHALL, on that fetch for op=000: perform LDI/NOP within the same edge, set PC<=PC+1, stay in FETCH; HALT -> HALT state, PC unchanged.
REQ-016 SHALL, on that fetch for op!=000, go to ISSUE.
REQ-017 SHALL, in ISSUE only, drive alu_instr=op, alu_A=R[rs1], alu_B=R[rs2] and alu_branch_addr=target; ISSUE always lasts exactly 1 cycle -> WB.
REQ-018 SHALL drive alu_instr=000 in every state other than ISSUE; alu_A, alu_B and alu_branch_addr are 0 outside ISSUE.
REQ-019 SHALL, in WB (exactly 1 cycle), sample alu_out and the flags at the end of WB, then go to FETCH.
REQ-020 SHALL, in WB for ops 001..110: R[rd]<=alu_out, carry<=alu_co (0 for ops 011..110), eq<=alu_eq, PC<=PC+1.
REQ-021 SHALL, in WB for op=111: write no register, carry<=0, eq<=0; PC<=target if eq was 1 at issue, else PC+1; alu_branch=0 in WB is ignored.
REQ-022 SHALL latch eq only from an op=110 result; any other ALU op clears it, so a branch is taken only directly after a compare, while LDI/NOP leave eq and carry unchanged.
REQ-023 SHALL let PC wrap modulo 64, so PC+1 from 63 is 0, including when branching to target 63 and then incrementing.
REQ-024 SHALL set busy=1 in FETCH, ISSUE and WB, otherwise 0, and set halted=1 only in HALT.
REQ-025 SHALL leave HALT only by reset.
REQ-026 SHALL wait indefinitely for imem_ack in FETCH, with imem_addr held stable.
REQ-027 SHALL use the fetch latency of (ack wait+1) cycles and the ALU op latency of fetch+2 cycles.

Reset
REQ-028 SHALL make RST=1 immediately (asynchronously) force state=IDLE, PC=0, IR=0, R0..R3=0, carry=0, eq=0, imem_req=0, alu_instr=000, busy=0 and halted=0.
REQ-029 SHALL let reset asserted mid-FETCH/ISSUE/WB abort the instruction with no register writeback, and ignore any later imem_ack until the next start.
REQ-030 SHALL resume normal operation on the first rising CLK edge after RST deasserts.

Verification
REQ-031 SHALL cover scenario LDI R1,0x0F; LDI R2,0xF1; ADD R3,R1,R2; HALT -> R3=0x00, carry=1, halted=1, pc=3.
REQ-032 SHALL cover scenario R1=0x05, R2=0x05; EQ R0,R1,R2; BRANCH target=0x20 -> R0=0x01, then fetch from imem_addr=0x20, with eq=0 after the branch.
REQ-033 SHALL cover scenario EQ with 0x05 vs 0x06 then BRANCH 0x20 -> not taken, PC advances by 1, R0=0x00.
REQ-034 SHALL cover scenario EQ equal; ADD; BRANCH -> not taken, because eq was cleared by the ADD.
REQ-035 SHALL cover scenario imem_ack delayed 5 cycles -> imem_req held and imem_addr stable for 5 cycles, alu_instr=000 throughout.
REQ-036 SHALL cover scenario RST pulsed during WB of SUB -> destination register unchanged (0), state IDLE, busy=0; a new start re-fetches PC 0.
